// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Handles one RISC-V load or store at a time, between the execute stage and
//   a data memory that reads combinationally and writes on the rising edge.
//   It forms byte enables and lane-aligned write data for SB/SH/SW. For loads
//   (LB/LH/LW/LBU/LHU) it sign- or zero-extends the result. An access that
//   crosses a word boundary is split into two word beats. If
//   SUPPORT_MISALIGNED=0, such an access faults instead.
//
// Ports
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   req_*                request channel (valid/ready). An accept happens in
//                        any cycle where req_valid and req_ready are both high.
//   resp_valid           one-cycle completion pulse; there is no backpressure
//   resp_load_data       extended load result; 0 for stores and faults
//   resp_fault           illegal funct3 or a disallowed misalignment
//   mem_address          word address of the current beat
//   mem_write_data       lane-aligned store data of the current beat
//   mem_write_enable     byte-lane enables of the current beat
//   store_enable         high only in the beats of a store
//   mem_read_data        combinational read of mem_address
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [31:0] resp_load_data,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_enable,
  output logic        store_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Access size in bytes, taken from funct3[1:0]. The code 11 is rejected
  // elsewhere, so its value here does not matter.
  function automatic logic [2:0] access_size(input logic [1:0] f3_low);
    case (f3_low)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] size);
    return ({2'b00, off} + {1'b0, size}) > 4'd4;
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] size);
    case (size)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        fault_q, fault_d;

  logic        accept;
  logic        req_illegal;
  logic        req_split;
  logic [1:0]  off;
  logic [2:0]  size;
  logic        split;
  logic [7:0]  lane_mask8;
  logic [63:0] data64;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;

  assign req_ready = (state_q == ST_IDLE) && reset_n;
  assign accept    = req_valid && req_ready;

  // funct3 011, 110 and 111 are never legal. A store may not use the
  // unsigned-load codes 100 and 101.
  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_is_store && req_funct3[2]);
  assign req_split   = crosses_word(req_address[1:0], access_size(req_funct3[1:0]));

  assign off   = addr_q[1:0];
  assign size  = access_size(funct3_q[1:0]);
  assign split = crosses_word(off, size);

  // The mask and data are computed over two words. The low half goes out
  // with beat 0 and the high half with beat 1.
  assign lane_mask8 = {4'b0000, size_mask(size)} << off;
  assign data64     = {32'h0000_0000, store_data_q} << {off, 3'b000};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    fault_d      = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          is_store_d   = req_is_store;
          funct3_d     = req_funct3;
          addr_d       = req_address;
          store_data_d = req_store_data;
          lo_d         = 32'h0;
          hi_d         = 32'h0;
          fault_d      = req_illegal || (req_split && !SUPPORT_MISALIGNED);
          // A faulting request skips the memory beats entirely.
          state_d      = fault_d ? ST_RESP : ST_ACC0;
        end
      end
      ST_ACC0: begin
        if (!is_store_q) lo_d = mem_read_data;
        state_d = split ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        if (!is_store_q) hi_d = mem_read_data;
        state_d = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      lo_q         <= 32'h0;
      hi_q         <= 32'h0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      fault_q      <= fault_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory beat outputs. They are decoded from state only, so store_enable
  // drops as soon as reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_address      = 32'h0;
    mem_write_data   = 32'h0;
    mem_write_enable = 4'b0000;
    store_enable     = 1'b0;
    case (state_q)
      ST_ACC0: begin
        mem_address      = {addr_q[31:2], 2'b00};
        mem_write_data   = data64[31:0];
        mem_write_enable = lane_mask8[3:0];
        store_enable     = is_store_q;
      end
      ST_ACC1: begin
        mem_address      = {addr_q[31:2] + 30'd1, 2'b00};
        mem_write_data   = data64[63:32];
        mem_write_enable = lane_mask8[7:4];
        store_enable     = is_store_q;
      end
      default: begin
        mem_address      = 32'h0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Response: pick the addressed bytes out of {hi,lo}, then extend them.
  // -------------------------------------------------------------------------
  assign load_shifted = 32'({hi_q, lo_q} >> {off, 3'b000});

  always_comb begin
    load_ext = 32'h0;
    case (funct3_q)
      3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b010:  load_ext = load_shifted;
      3'b100:  load_ext = {24'h0, load_shifted[7:0]};
      3'b101:  load_ext = {16'h0, load_shifted[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  assign resp_valid     = (state_q == ST_RESP);
  assign resp_fault     = resp_valid && fault_q;
  assign resp_load_data = (resp_valid && !is_store_q && !fault_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;

  // Index 0: SUPPORT_MISALIGNED=1, index 1: SUPPORT_MISALIGNED=0.
  // Both DUTs get the same request stream.
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_fault;
  logic [1:0]  store_enable;
  logic [31:0] resp_load_data [2];
  logic [31:0] mem_address    [2];
  logic [31:0] mem_write_data [2];
  logic [3:0]  mem_write_enable [2];
  logic [31:0] mem_read_data  [2];

  logic [31:0] mem [2][64];
  logic        mem_clear;
  logic [7:0]  ref_mem [2][256];

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Beat trace of DUT 0, indexed by cycles after the accept edge
  logic [31:0] b_addr [0:5];
  logic [31:0] b_data [0:5];
  logic [3:0]  b_en   [0:5];
  logic        b_se   [0:5];

  always #5 clock = ~clock;

  load_store_unit #(.SUPPORT_MISALIGNED(1'b1)) u_dut_mis (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(resp_valid[0]), .resp_load_data(resp_load_data[0]),
    .resp_fault(resp_fault[0]), .mem_address(mem_address[0]),
    .mem_write_data(mem_write_data[0]), .mem_write_enable(mem_write_enable[0]),
    .store_enable(store_enable[0]), .mem_read_data(mem_read_data[0])
  );

  load_store_unit #(.SUPPORT_MISALIGNED(1'b0)) u_dut_nomis (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(resp_valid[1]), .resp_load_data(resp_load_data[1]),
    .resp_fault(resp_fault[1]), .mem_address(mem_address[1]),
    .mem_write_data(mem_write_data[1]), .mem_write_enable(mem_write_enable[1]),
    .store_enable(store_enable[1]), .mem_read_data(mem_read_data[1])
  );

  // 256-byte data memories. The address aliases above bit 7.
  assign mem_read_data[0] = mem[0][mem_address[0][7:2]];
  assign mem_read_data[1] = mem[1][mem_address[1][7:2]];

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int s = 0; s < 2; s++)
        for (int w = 0; w < 64; w++) mem[s][w] <= 32'h0;
    end else begin
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < 4; b++)
          if (store_enable[s] && mem_write_enable[s][b])
            mem[s][mem_address[s][7:2]][b*8 +: 8] <= mem_write_data[s][b*8 +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model. It works byte by byte from the architectural rules
  // and has no notion of beats or states.
  task automatic ref_access(input int s, input bit st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            output logic fault, output int lat, output logic [31:0] rd);
    int size;
    bit illegal, split;
    logic [31:0] v;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3[2]);
    split   = (int'(addr[1:0]) + size) > 4;
    fault   = illegal || (split && s == 1);
    lat     = fault ? 1 : (split ? 3 : 2);
    rd      = 32'h0;
    if (!fault) begin
      if (st) begin
        for (int i = 0; i < size; i++) ref_mem[s][8'(addr + i)] = data[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[s][8'(addr + i)];
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  // Send one request to both DUTs, watch 5 cycles, and check the response
  // and beat activity of each one against the model.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] r0);
    int lat [2];
    int pulses [2];
    logic [31:0] rdata [2];
    logic rfault [2];
    bit beat_seen [2];
    logic e_fault;
    int e_lat;
    logic [31:0] e_rd;
    @(negedge clock);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_address = addr; req_store_data = data;
    check_eq("ready_before_accept0", 32'(req_ready[0]), 32'd1);
    check_eq("ready_before_accept1", 32'(req_ready[1]), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      lat[s] = 0; pulses[s] = 0; rdata[s] = 32'h0; rfault[s] = 1'b0; beat_seen[s] = 1'b0;
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      b_addr[k] = mem_address[0]; b_data[k] = mem_write_data[0];
      b_en[k] = mem_write_enable[0]; b_se[k] = store_enable[0];
      for (int s = 0; s < 2; s++) begin
        if (store_enable[s] || mem_write_enable[s] != 4'b0000) beat_seen[s] = 1'b1;
        if (resp_valid[s]) begin
          pulses[s]++;
          if (lat[s] == 0) begin
            lat[s] = k; rdata[s] = resp_load_data[s]; rfault[s] = resp_fault[s];
          end
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      ref_access(s, st, f3, addr, data, e_fault, e_lat, e_rd);
      check_eq($sformatf("latency%0d", s), 32'(lat[s]), 32'(e_lat));
      check_eq($sformatf("pulses%0d", s), 32'(pulses[s]), 32'd1);
      check_eq($sformatf("fault%0d", s), 32'(rfault[s]), 32'(e_fault));
      check_eq($sformatf("load_data%0d", s), rdata[s], e_rd);
      check_eq($sformatf("beat_seen%0d", s), 32'(beat_seen[s]), 32'(!e_fault));
    end
    r0 = rdata[0];
    n_txn++;
    $display("txn %0d: st=%0b f3=%0d addr=0x%08h data=0x%08h -> lat=%0d/%0d fault=%0b/%0b rdata=0x%08h/0x%08h",
             n_txn, st, f3, addr, data, lat[0], lat[1], rfault[0], rfault[1], rdata[0], rdata[1]);
  endtask

  initial begin
    logic [31:0] r;
    logic e_fault;
    int e_lat;
    logic [31:0] e_rd;
    logic [31:0] exp_b2b [3];
    int acc, nresp, last_resp;
    bit hs;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) ref_mem[s][i] = 8'h00;
    reset_n = 1'b0; mem_clear = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'b000; req_address = 32'h0; req_store_data = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ready", 32'(req_ready[0]), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_store_enable", 32'(store_enable), 32'd0);
    check_eq("rst_wen", 32'(mem_write_enable[0]), 32'd0);
    check_eq("rst_mem_address", mem_address[0], 32'h0);
    check_eq("rst_load_data", resp_load_data[0], 32'h0);
    mem_clear = 1'b0;
    reset_n = 1'b1;
    #1 check_eq("post_rst_ready", 32'(req_ready), 32'd3);

    // 1: aligned word store and load
    do_req(1'b1, 3'b010, 32'h10, 32'h11223344, r);
    check_eq("t1_addr", b_addr[1], 32'h10);
    check_eq("t1_en", 32'(b_en[1]), 32'hF);
    check_eq("t1_data", b_data[1], 32'h11223344);
    check_eq("t1_se_beat", 32'(b_se[1]), 32'd1);
    check_eq("t1_se_after", 32'(b_se[2]), 32'd0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, r);
    check_eq("t1_lw", r, 32'h11223344);

    // 2: byte store, then signed and unsigned byte loads
    do_req(1'b1, 3'b000, 32'h21, 32'h80, r);
    check_eq("t2_en", 32'(b_en[1]), 32'h2);
    check_eq("t2_data", b_data[1], 32'h00008000);
    do_req(1'b0, 3'b000, 32'h21, 32'h0, r);
    check_eq("t2_lb", r, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h21, 32'h0, r);
    check_eq("t2_lbu", r, 32'h00000080);

    // 3: a word store and load that cross a word boundary
    do_req(1'b1, 3'b010, 32'h0E, 32'hAABBCCDD, r);
    check_eq("t3_b0_addr", b_addr[1], 32'h0C);
    check_eq("t3_b0_en", 32'(b_en[1]), 32'hC);
    check_eq("t3_b0_data", b_data[1], 32'hCCDD0000);
    check_eq("t3_b1_addr", b_addr[2], 32'h10);
    check_eq("t3_b1_en", 32'(b_en[2]), 32'h3);
    check_eq("t3_b1_data", b_data[2], 32'h0000AABB);
    check_eq("t3_se_after", 32'(b_se[3]), 32'd0);
    do_req(1'b0, 3'b010, 32'h0E, 32'h0, r);
    check_eq("t3_lw", r, 32'hAABBCCDD);

    // 4: faults. The no-misalign DUT faults on the first one. Both DUTs
    // fault on the illegal funct3 and on the unsigned-code store.
    do_req(1'b0, 3'b001, 32'h03, 32'h0, r);
    do_req(1'b0, 3'b011, 32'h08, 32'h0, r);
    do_req(1'b1, 3'b100, 32'h08, 32'h55, r);

    // 5: reset asserted during beat 1 of a split store
    do_req(1'b1, 3'b010, 32'h0C, 32'h0, r);
    do_req(1'b1, 3'b010, 32'h10, 32'h0, r);
    @(negedge clock);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_address = 32'h0E; req_store_data = 32'hAABBCCDD;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_eq("t5_se_in_acc1", 32'(store_enable[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_se_async_drop", 32'(store_enable[0]), 32'd0);
    check_eq("t5_no_resp", 32'(resp_valid[0]), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check_eq("t5_no_resp_rst", 32'(resp_valid[0]), 32'd0);
    end
    reset_n = 1'b1;
    #1 check_eq("t5_ready_after", 32'(req_ready), 32'd3);
    ref_mem[0][8'h0E] = 8'hDD;   // beat 0 committed before the reset
    ref_mem[0][8'h0F] = 8'hCC;
    do_req(1'b0, 3'b010, 32'h0C, 32'h0, r);
    check_eq("t5_lw_0c", r, 32'hCCDD0000);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, r);
    check_eq("t5_lw_10", r, 32'h0);

    // Randomized mix of loads and stores, including illegal codes
    for (int t = 0; t < 150; t++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom, r);

    // 6: req_valid held high for three back-to-back LWs
    for (int j = 0; j < 3; j++) begin
      ref_access(0, 1'b0, 3'b010, 32'h10 + 32'(4*j), 32'h0, e_fault, e_lat, e_rd);
      exp_b2b[j] = e_rd;
    end
    acc = 0; nresp = 0; last_resp = -1;
    @(negedge clock);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_address = 32'h10;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clock);
      check_eq($sformatf("t6_ready_c%0d", c), 32'(req_ready[0]),
               32'((c % 3 == 0) || c >= 9));
      if (resp_valid[0]) begin
        if (nresp < 3) check_eq($sformatf("t6_data%0d", nresp), resp_load_data[0], exp_b2b[nresp]);
        if (nresp > 0) check_eq("t6_spacing", 32'(c - last_resp), 32'd3);
        last_resp = c;
        nresp++;
      end
      hs = req_valid && req_ready[0];
      @(posedge clock);
      #1;
      if (hs) begin
        acc++;
        if (acc == 3) req_valid = 1'b0;
        else req_address = req_address + 32'd4;
      end
    end
    check_eq("t6_resp_count", 32'(nresp), 32'd3);
    $display("txn %0d: back-to-back LW x3, responses=%0d", n_txn + 1, nresp);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
